simmem_wdata_tracker: RTL and testbench



---
 rtl/simmem_wdata_tracker.sv | 116 +++++++++++
 tb/tb_simmem_wdata_tracker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/simmem_wdata_tracker.sv
// Matches write data beats to write addresses for the simulated memory delay core.
// Beats that arrive before their address are counted and delivered with the address.
module simmem_wdata_tracker #(
    parameter int unsigned BurstLenW     = 8,
    parameter int unsigned IidW          = 4,
    parameter int unsigned Depth         = 8,
    parameter int unsigned MaxEarlyBeats = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   waddr_valid_i,
    output logic                                   waddr_ready_o,
    input  logic [BurstLenW-1:0]                   waddr_burst_len_i,
    input  logic [IidW-1:0]                        waddr_iid_i,
    input  logic                                   wdata_valid_i,
    output logic                                   wdata_ready_o,
    output logic                                   addr_valid_o,
    input  logic                                   addr_ready_i,
    output logic [BurstLenW:0]                     addr_imm_cnt_o,
    output logic                                   beat_valid_o,
    output logic [IidW-1:0]                        beat_iid_o,
    output logic                                   burst_done_o,
    output logic [IidW-1:0]                        done_iid_o,
    output logic [$clog2(MaxEarlyBeats+1)-1:0]     early_cnt_o,
    output logic [$clog2(Depth+1)-1:0]             pending_cnt_o
);

    localparam int unsigned EW = $clog2(MaxEarlyBeats + 1);
    localparam int unsigned PW = $clog2(Depth + 1);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = BurstLenW + 1;
    localparam int unsigned CW = ((EW > LW) ? EW : LW) + 1;

    logic [EW-1:0]   e_q, e_d;
    logic [PW-1:0]   cnt_q;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [IidW-1:0] iid_mem [Depth];
    logic [LW-1:0]   rem_mem [Depth];

    logic            empty, full;
    logic            beat_acc, addr_acc, early_beat;
    logic            imm_done, push, pop;
    logic [CW-1:0]   len, e_next;
    logic [IidW-1:0] head_iid;
    logic [LW-1:0]   head_rem, push_rem;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == PW'(Depth));
    assign head_iid = iid_mem[rd_ptr_q];
    assign head_rem = rem_mem[rd_ptr_q];

    assign wdata_ready_o = !empty || (e_q < EW'(MaxEarlyBeats));
    assign addr_valid_o  = waddr_valid_i && !full;
    assign waddr_ready_o = addr_ready_i && !full;

    assign beat_acc   = wdata_valid_i && wdata_ready_o;
    assign addr_acc   = waddr_valid_i && waddr_ready_o;
    assign early_beat = beat_acc && empty;

    assign len    = CW'(waddr_burst_len_i) + CW'(1);
    assign e_next = CW'(e_q) + CW'(early_beat);

    // An address arriving to an empty FIFO completes immediately if enough beats are banked.
    assign imm_done = addr_acc && empty && (e_next >= len);
    assign push     = addr_acc && !imm_done;
    assign pop      = beat_acc && !empty && (head_rem == LW'(1));
    // With a non-empty FIFO e_next is zero, so this also yields the full length.
    assign push_rem = LW'(len - e_next);

    always_comb begin
        addr_imm_cnt_o = '0;
        e_d            = EW'(e_next);
        if (addr_acc && empty) begin
            if (imm_done) begin
                addr_imm_cnt_o = LW'(len);
                e_d            = EW'(e_next - len);
            end else begin
                addr_imm_cnt_o = LW'(e_next);
                e_d            = '0;
            end
        end
    end

    assign beat_valid_o  = beat_acc && !empty;
    assign beat_iid_o    = head_iid;
    assign burst_done_o  = imm_done || pop;
    assign done_iid_o    = empty ? waddr_iid_i : head_iid;
    assign early_cnt_o   = e_q;
    assign pending_cnt_o = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e_q      <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            e_q   <= e_d;
            cnt_q <= cnt_q + PW'(push) - PW'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            iid_mem[wr_ptr_q] <= waddr_iid_i;
            rem_mem[wr_ptr_q] <= push_rem;
        end
        if (beat_acc && !empty && !pop) begin
            rem_mem[rd_ptr_q] <= head_rem - LW'(1);
        end
    end

endmodule

// File: tb/tb_simmem_wdata_tracker.sv
// Randomised and directed checks of simmem_wdata_tracker against a queue-based model.
module tb_simmem_wdata_tracker;
    localparam int BLW   = 3;
    localparam int IW    = 4;
    localparam int DEPTH = 4;
    localparam int MAXE  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic waddr_valid = 1'b0, wdata_valid = 1'b0, addr_ready = 1'b0;
    logic [BLW-1:0] burst_len = '0;
    logic [IW-1:0]  waddr_iid = '0;
    logic waddr_ready, wdata_ready, addr_valid, beat_valid, burst_done;
    logic [BLW:0]   addr_imm_cnt;
    logic [IW-1:0]  beat_iid, done_iid;
    logic [$clog2(MAXE+1)-1:0]  early_cnt;
    logic [$clog2(DEPTH+1)-1:0] pending_cnt;

    always #5 clk = ~clk;

    simmem_wdata_tracker #(.BurstLenW(BLW), .IidW(IW), .Depth(DEPTH), .MaxEarlyBeats(MAXE)) dut (
        .clk_i(clk), .rst_i(rst),
        .waddr_valid_i(waddr_valid), .waddr_ready_o(waddr_ready),
        .waddr_burst_len_i(burst_len), .waddr_iid_i(waddr_iid),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
        .addr_valid_o(addr_valid), .addr_ready_i(addr_ready),
        .addr_imm_cnt_o(addr_imm_cnt),
        .beat_valid_o(beat_valid), .beat_iid_o(beat_iid),
        .burst_done_o(burst_done), .done_iid_o(done_iid),
        .early_cnt_o(early_cnt), .pending_cnt_o(pending_cnt)
    );

    typedef struct { int iid; int rem; } ent_t;
    ent_t q[$];
    int   m_e = 0;

    int n_total = 0;
    int n_pass  = 0;
    int obs_imm, obs_done, obs_diid, obs_bv, obs_biid, obs_wdr, obs_war, obs_av;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive one cycle, compare all outputs with the model, then advance the model.
    task automatic step(input bit av, input int bl, input int iid, input bit dv, input bit ar);
        int  sz, e0, len, en;
        bit  full, wr, beat, acc;
        int  x_imm, x_done, x_diid, x_bv, x_biid;
        @(negedge clk);
        waddr_valid = av; burst_len = BLW'(bl); waddr_iid = IW'(iid);
        wdata_valid = dv; addr_ready = ar;
        #1;
        sz   = q.size();
        e0   = m_e;
        full = (sz == DEPTH);
        wr   = (sz > 0) || (e0 < MAXE);
        beat = dv && wr;
        acc  = av && ar && !full;
        len  = bl + 1;
        en   = e0 + ((beat && sz == 0) ? 1 : 0);
        x_imm = 0; x_done = 0; x_diid = 0; x_bv = 0; x_biid = 0;
        if (beat && sz > 0) begin
            x_bv   = 1;
            x_biid = q[0].iid;
            q[0].rem = q[0].rem - 1;
            if (q[0].rem == 0) begin
                x_done = 1;
                x_diid = q[0].iid;
                void'(q.pop_front());
            end
        end
        if (acc) begin
            if (sz == 0) begin
                if (en >= len) begin
                    x_imm = len; m_e = en - len; x_done = 1; x_diid = iid;
                end else begin
                    x_imm = en; m_e = 0; q.push_back('{iid, len - en});
                end
            end else begin
                q.push_back('{iid, len});
            end
        end else begin
            m_e = en;
        end
        chk("wdata_ready", 32'(wdata_ready), 32'(wr));
        chk("waddr_ready", 32'(waddr_ready), 32'(ar && !full));
        chk("addr_valid", 32'(addr_valid), 32'(av && !full));
        chk("early_cnt", 32'(early_cnt), 32'(e0));
        chk("pending_cnt", 32'(pending_cnt), 32'(sz));
        chk("addr_imm_cnt", 32'(addr_imm_cnt), 32'(x_imm));
        chk("beat_valid", 32'(beat_valid), 32'(x_bv));
        chk("burst_done", 32'(burst_done), 32'(x_done));
        if (x_bv != 0)   chk("beat_iid", 32'(beat_iid), 32'(x_biid));
        if (x_done != 0) chk("done_iid", 32'(done_iid), 32'(x_diid));
        obs_imm = 32'(addr_imm_cnt); obs_done = 32'(burst_done); obs_diid = 32'(done_iid);
        obs_bv = 32'(beat_valid); obs_biid = 32'(beat_iid);
        obs_wdr = 32'(wdata_ready); obs_war = 32'(waddr_ready); obs_av = 32'(addr_valid);
    endtask

    task automatic after_edge(input string name, input int exp_e, input int exp_p);
        @(posedge clk); #1;
        chk({name, "_early"}, 32'(early_cnt), 32'(exp_e));
        chk({name, "_pending"}, 32'(pending_cnt), 32'(exp_p));
    endtask

    // Asynchronous reset: outputs must settle without any clock edge.
    task automatic do_reset(input string name);
        @(negedge clk);
        waddr_valid = 1'b0; wdata_valid = 1'b0; addr_ready = 1'b1;
        burst_len = '0; waddr_iid = '0;
        rst = 1'b1;
        #1;
        chk({name, "_pending"}, 32'(pending_cnt), 0);
        chk({name, "_early"}, 32'(early_cnt), 0);
        chk({name, "_wdata_ready"}, 32'(wdata_ready), 1);
        chk({name, "_waddr_ready"}, 32'(waddr_ready), 1);
        chk({name, "_addr_valid"}, 32'(addr_valid), 0);
        chk({name, "_beat_valid"}, 32'(beat_valid), 0);
        chk({name, "_burst_done"}, 32'(burst_done), 0);
        q.delete();
        m_e = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset("reset0");

        // Three early beats, then a 4-beat address completes with one late beat.
        repeat (3) step(0, 0, 0, 1, 0);
        step(1, 3, 5, 0, 1);
        chk("s36_imm", obs_imm, 3);
        chk("s36_done_none", obs_done, 0);
        after_edge("s36", 0, 1);
        step(0, 0, 0, 1, 0);
        chk("s36_beat", obs_bv, 1);
        chk("s36_beat_iid", obs_biid, 5);
        chk("s36_done", obs_done, 1);
        chk("s36_done_iid", obs_diid, 5);

        // Five early beats cover a 4-beat burst with one left over.
        repeat (5) step(0, 0, 0, 1, 0);
        step(1, 3, 2, 0, 1);
        chk("s37_imm", obs_imm, 4);
        chk("s37_done", obs_done, 1);
        chk("s37_done_iid", obs_diid, 2);
        after_edge("s37", 1, 0);
        step(1, 0, 1, 0, 1);

        // Address and its single beat in the same cycle.
        step(1, 0, 7, 1, 1);
        chk("s38_imm", obs_imm, 1);
        chk("s38_done", obs_done, 1);
        chk("s38_done_iid", obs_diid, 7);
        after_edge("s38", 0, 0);

        // Early-beat store fills, then an address drains two beats.
        repeat (MAXE) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("s39_full_ready", obs_wdr, 0);
        step(1, 1, 3, 0, 1);
        after_edge("s39", MAXE - 2, 0);
        chk("s39_ready", 32'(wdata_ready), 1);
        step(1, 5, 4, 0, 1);

        // Pending FIFO fills, backpressure on the address channel, then a pop frees it.
        for (int i = 0; i < DEPTH; i++) step(1, 1, i, 0, 1);
        step(1, 1, 9, 0, 1);
        chk("s40_waddr_ready", obs_war, 0);
        chk("s40_addr_valid", obs_av, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("s40_pop", obs_done, 1);
        after_edge("s40", 0, DEPTH - 1);
        chk("s40_waddr_ready_after", 32'(waddr_ready), 1);
        repeat (2 * (DEPTH - 1)) step(0, 0, 0, 1, 0);

        // Reset with two entries pending.
        step(1, 1, 1, 0, 1);
        step(1, 1, 2, 0, 1);
        after_edge("s41_pre", 0, 2);
        do_reset("s41");

        for (int i = 0; i < 1500; i++)
            step(($urandom % 2) == 1, int'($urandom % 8), int'($urandom % 16),
                 ($urandom % 10) < 6, ($urandom % 10) < 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
